// File: rtl/fft_pkg.sv
// Constants and FSM encoding shared by the FFT stage and its post-processing blocks.
package fft_pkg;

    localparam int unsigned FFT_LEN_DEF = 2048;
    localparam int unsigned AMP_W_DEF   = 47;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } pf_state_e;

endpackage

// File: rtl/peak_cmp.sv
// Argmax step: folds one bin into the running best when it lies in the search window.
module peak_cmp #(
    parameter int unsigned AMP_W  = 47,
    parameter int unsigned BIN_W  = 11,
    parameter int unsigned LO_BIN = 2,
    parameter int unsigned HI_BIN = 1023
) (
    input  logic             i_clear,
    input  logic [BIN_W-1:0] i_bin,
    input  logic [AMP_W-1:0] i_amp,
    input  logic [AMP_W-1:0] i_best_amp,
    input  logic [BIN_W-1:0] i_best_bin,
    output logic [AMP_W-1:0] o_best_amp_c,
    output logic [BIN_W-1:0] o_best_bin_c
);

    logic             w_lo_ok;
    logic             w_in_win;
    logic [AMP_W-1:0] w_base_amp;
    logic [BIN_W-1:0] w_base_bin;

    generate
        if (LO_BIN == 0) begin : g_no_skip
            assign w_lo_ok = 1'b1;
        end else begin : g_skip
            assign w_lo_ok = (i_bin >= BIN_W'(LO_BIN));
        end
    endgenerate

    assign w_in_win   = w_lo_ok && (i_bin <= BIN_W'(HI_BIN));
    // A new frame starts from amp=0 at the first searchable bin.
    assign w_base_amp = i_clear ? '0 : i_best_amp;
    assign w_base_bin = i_clear ? BIN_W'(LO_BIN) : i_best_bin;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        o_best_amp_c = w_base_amp;
        o_best_bin_c = w_base_bin;
        if (w_in_win && (i_amp > w_base_amp)) begin
            o_best_amp_c = i_amp;
            o_best_bin_c = i_bin;
        end
    end

endmodule

// File: rtl/spectrum_peak_finder.sv
// Per-frame argmax over the lower half of an FFT magnitude stream, with a
// held result, overrun flag and gap-timeout frame abort.
module spectrum_peak_finder
    import fft_pkg::*;
#(
    parameter int unsigned FFT_LEN     = FFT_LEN_DEF,
    parameter int unsigned AMP_W       = AMP_W_DEF,
    parameter int unsigned SKIP_BINS   = 2,
    parameter int unsigned GAP_TIMEOUT = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AMP_W-1:0]           amp,
    input  logic                       amp_valid,
    input  logic [AMP_W-1:0]           threshold,
    output logic [$clog2(FFT_LEN)-1:0] peak_bin,
    output logic [AMP_W-1:0]           peak_amp,
    output logic                       peak_hit,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [15:0]                frame_cnt,
    output logic                       overrun,
    output logic                       frame_err
);

    localparam int unsigned BIN_W  = $clog2(FFT_LEN);
    localparam int unsigned GAP_W  = $clog2(GAP_TIMEOUT + 1);
    localparam int unsigned HI_BIN = FFT_LEN / 2 - 1;

    pf_state_e        r_state;
    logic [BIN_W-1:0] r_bin_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [AMP_W-1:0] r_best_amp;
    logic [BIN_W-1:0] r_best_bin;
    logic [BIN_W-1:0] r_peak_bin;
    logic [AMP_W-1:0] r_peak_amp;
    logic             r_peak_hit;
    logic             r_result_valid;
    logic [15:0]      r_frame_cnt;
    logic             r_overrun;
    logic             r_frame_err;

    logic [AMP_W-1:0] w_nxt_amp;
    logic [BIN_W-1:0] w_nxt_bin;
    logic             w_last;
    logic             w_gap_abort;

    assign w_last      = (r_bin_cnt == BIN_W'(FFT_LEN - 1));
    assign w_gap_abort = (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1));

    peak_cmp #(
        .AMP_W  (AMP_W),
        .BIN_W  (BIN_W),
        .LO_BIN (SKIP_BINS),
        .HI_BIN (HI_BIN)
    ) u_peak_cmp (
        .i_clear      (r_state == ST_IDLE),
        .i_bin        (r_bin_cnt),
        .i_amp        (amp),
        .i_best_amp   (r_best_amp),
        .i_best_bin   (r_best_bin),
        .o_best_amp_c (w_nxt_amp),
        .o_best_bin_c (w_nxt_bin)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_bin_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_best_amp     <= '0;
            r_best_bin     <= '0;
            r_peak_bin     <= '0;
            r_peak_amp     <= '0;
            r_peak_hit     <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_cnt    <= '0;
            r_overrun      <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_result_valid && result_ready) begin
                r_result_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (amp_valid) begin
                        r_state    <= ST_SCAN;
                        r_bin_cnt  <= r_bin_cnt + BIN_W'(1);
                        r_gap_cnt  <= '0;
                        r_best_amp <= w_nxt_amp;
                        r_best_bin <= w_nxt_bin;
                    end
                end
                ST_SCAN: begin
                    if (amp_valid) begin
                        r_gap_cnt  <= '0;
                        r_bin_cnt  <= r_bin_cnt + BIN_W'(1);
                        r_best_amp <= w_nxt_amp;
                        r_best_bin <= w_nxt_bin;
                        // Last bin: publish; an unaccepted older result is lost.
                        if (w_last) begin
                            r_state        <= ST_IDLE;
                            r_peak_bin     <= w_nxt_bin;
                            r_peak_amp     <= w_nxt_amp;
                            r_peak_hit     <= (w_nxt_amp >= threshold);
                            r_frame_cnt    <= r_frame_cnt + 16'd1;
                            r_result_valid <= 1'b1;
                            r_overrun      <= r_result_valid && !result_ready;
                        end
                    end else if (w_gap_abort) begin
                        r_state     <= ST_IDLE;
                        r_bin_cnt   <= '0;
                        r_gap_cnt   <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign peak_bin     = r_peak_bin;
    assign peak_amp     = r_peak_amp;
    assign peak_hit     = r_peak_hit;
    assign result_valid = r_result_valid;
    assign frame_cnt    = r_frame_cnt;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Self-checking bench for spectrum_peak_finder: directed frames plus randomized
// frames compared against an array-based argmax reference.
module tb_spectrum_peak_finder;

    localparam int unsigned FFT_LEN     = 2048;
    localparam int unsigned AMP_W       = 47;
    localparam int unsigned SKIP_BINS   = 2;
    localparam int unsigned GAP_TIMEOUT = 16;
    localparam int unsigned BIN_W       = $clog2(FFT_LEN);

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [AMP_W-1:0] amp;
    logic             amp_valid;
    logic [AMP_W-1:0] threshold;
    logic [BIN_W-1:0] peak_bin;
    logic [AMP_W-1:0] peak_amp;
    logic             peak_hit;
    logic             result_valid;
    logic             result_ready;
    logic [15:0]      frame_cnt;
    logic             overrun;
    logic             frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int ov_cnt   = 0;
    int ferr_cnt = 0;

    logic [AMP_W-1:0] frame_amp [FFT_LEN];

    logic             exp_valid;
    logic [BIN_W-1:0] exp_bin;
    logic [AMP_W-1:0] exp_amp;
    logic             exp_hit;
    logic [15:0]      exp_cnt;
    int               exp_ov;
    int               exp_ferr;

    spectrum_peak_finder #(
        .FFT_LEN     (FFT_LEN),
        .AMP_W       (AMP_W),
        .SKIP_BINS   (SKIP_BINS),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .amp          (amp),
        .amp_valid    (amp_valid),
        .threshold    (threshold),
        .peak_bin     (peak_bin),
        .peak_amp     (peak_amp),
        .peak_hit     (peak_hit),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 aclk = ~aclk;

    // Pulse counters sampled on the falling edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (overrun)   ov_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference: largest value in the window, then its lowest index.
    function automatic void ref_peak(output logic [BIN_W-1:0] bin, output logic [AMP_W-1:0] best);
        best = '0;
        bin  = BIN_W'(SKIP_BINS);
        for (int i = int'(SKIP_BINS); i < int'(FFT_LEN / 2); i++)
            if (frame_amp[i] > best) best = frame_amp[i];
        for (int i = int'(FFT_LEN / 2) - 1; i >= int'(SKIP_BINS); i--)
            if (best != '0 && frame_amp[i] == best) bin = BIN_W'(i);
    endfunction

    task automatic drive_bins(input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) begin
            if (max_gap > 0 && i > 0 && $urandom_range(0, 15) == 0) begin
                amp_valid = 1'b0;
                amp       = AMP_W'($urandom());
                repeat ($urandom_range(1, max_gap)) tick();
            end
            amp       = frame_amp[i];
            amp_valid = 1'b1;
            tick();
        end
        amp_valid = 1'b0;
    endtask

    task automatic run_frame(input int max_gap, input bit ready_on_last);
        logic [BIN_W-1:0] b;
        logic [AMP_W-1:0] a;
        logic             pend;
        ref_peak(b, a);
        drive_bins(0, FFT_LEN - 2, max_gap);
        check("valid_before_last", 64'(result_valid), 64'(exp_valid));
        result_ready = ready_on_last;
        drive_bins(FFT_LEN - 1, FFT_LEN - 1, 0);
        pend      = exp_valid && !ready_on_last;
        exp_bin   = b;
        exp_amp   = a;
        exp_hit   = (a >= threshold);
        exp_cnt   = exp_cnt + 16'd1;
        exp_valid = 1'b1;
        if (pend) exp_ov++;
        result_ready = 1'b0;
        check("valid_latency", 64'(result_valid), 64'd1);
        check("overrun_pulse", 64'(overrun), 64'(pend));
    endtask

    task automatic check_result(input string tag);
        @(negedge aclk);
        #1;
        check({tag, ".valid"}, 64'(result_valid), 64'(exp_valid));
        check({tag, ".bin"},   64'(peak_bin),     64'(exp_bin));
        check({tag, ".amp"},   64'(peak_amp),     64'(exp_amp));
        check({tag, ".hit"},   64'(peak_hit),     64'(exp_hit));
        check({tag, ".cnt"},   64'(frame_cnt),    64'(exp_cnt));
        check({tag, ".ov"},    64'(ov_cnt),       64'(exp_ov));
        check({tag, ".ferr"},  64'(ferr_cnt),     64'(exp_ferr));
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        exp_valid    = 1'b0;
        check("accept_clears", 64'(result_valid), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(result_valid), 64'd0);
        check({tag, ".bin"},   64'(peak_bin),     64'd0);
        check({tag, ".amp"},   64'(peak_amp),     64'd0);
        check({tag, ".hit"},   64'(peak_hit),     64'd0);
        check({tag, ".cnt"},   64'(frame_cnt),    64'd0);
        check({tag, ".ov"},    64'(overrun),      64'd0);
        check({tag, ".ferr"},  64'(frame_err),    64'd0);
    endtask

    initial begin
        logic [BIN_W-1:0] rb;
        logic [AMP_W-1:0] ra;
        aresetn      = 1'b0;
        amp          = '0;
        amp_valid    = 1'b0;
        threshold    = '0;
        result_ready = 1'b0;
        exp_valid = 1'b0; exp_bin = '0; exp_amp = '0; exp_hit = 1'b0;
        exp_cnt = '0; exp_ov = 0; exp_ferr = 0;
        repeat (3) tick();
        check_zero("reset");
        aresetn = 1'b1;
        tick();

        // Ramp with one large bin above threshold.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'(i);
        frame_amp[300] = AMP_W'(1000000000);
        threshold      = AMP_W'(500000000);
        run_frame(0, 1'b0);
        check_result("ramp");
        accept();

        // Huge DC bins are skipped; equal peaks resolve to the lower index.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = '0;
        frame_amp[0]   = AMP_W'(64'd1 << 46);
        frame_amp[1]   = AMP_W'(64'd1 << 46);
        frame_amp[100] = AMP_W'(5000);
        frame_amp[200] = AMP_W'(5000);
        threshold      = AMP_W'(5001);
        run_frame(0, 1'b0);
        check_result("dc_tie");
        accept();

        // Upper half ignored; threshold equal to peak counts as a hit.
        for (int i = 0; i < int'(FFT_LEN); i++)
            frame_amp[i] = (i >= 2 && i <= 1023) ? AMP_W'(10) : '0;
        frame_amp[1500] = '1;
        threshold       = AMP_W'(10);
        run_frame(0, 1'b0);
        check_result("upper_half");
        accept();

        // Two back-to-back frames without reading: one overrun, second result held.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom_range(0, 1000));
        run_frame(0, 1'b0);
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom_range(0, 1000));
        run_frame(0, 1'b0);
        check_result("b2b");
        // Completion in the same cycle as acceptance is not an overrun.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom());
        run_frame(0, 1'b1);
        check_result("accept_on_complete");
        accept();

        // Gap timeout after bin 500 aborts the frame and discards its best.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'(100);
        frame_amp[400] = '1;
        drive_bins(0, 500, 0);
        repeat (GAP_TIMEOUT - 1) tick();
        check("gap_early", 64'(frame_err), 64'd0);
        tick();
        check("gap_abort", 64'(frame_err), 64'd1);
        exp_ferr++;
        tick();
        check("gap_pulse_end", 64'(frame_err), 64'd0);
        check_result("gap");
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom_range(0, 50));
        run_frame(0, 1'b0);
        check_result("after_gap");

        // Reset mid-frame clears everything; the next frame counts from 1.
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom());
        drive_bins(0, 1000, 0);
        aresetn = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (2) tick();
        aresetn   = 1'b1;
        exp_valid = 1'b0; exp_bin = '0; exp_amp = '0; exp_hit = 1'b0; exp_cnt = '0;
        tick();
        for (int i = 0; i < int'(FFT_LEN); i++) frame_amp[i] = AMP_W'($urandom_range(0, 100000));
        run_frame(0, 1'b0);
        check_result("post_reset");

        // Randomized frames with sub-timeout gaps and random reads.
        for (int f = 0; f < 6; f++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < int'(FFT_LEN); i++) begin
                if (mode == 0)
                    frame_amp[i] = AMP_W'({$urandom(), $urandom()});
                else if (mode == 1)
                    frame_amp[i] = AMP_W'($urandom_range(0, 3));
                else
                    frame_amp[i] = (i >= int'(SKIP_BINS) && i < int'(FFT_LEN / 2))
                                   ? '0 : AMP_W'({$urandom(), $urandom()});
            end
            ref_peak(rb, ra);
            threshold = ra + AMP_W'($urandom_range(0, 2)) - AMP_W'(1);
            run_frame(GAP_TIMEOUT - 1, 1'b0);
            check_result("rand");
            if ($urandom_range(0, 1) == 1) accept();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_finder.md
SPECTRUM_PEAK_FINDER -- requirements
Module: spectrum_peak_finder

Interface
REQ-001 SHALL have parameter FFT_LEN, default 2048, meaning bins per FFT frame (power of two).
REQ-002 SHALL have parameter AMP_W, default 47, meaning the magnitude-squared input width.
REQ-003 SHALL have parameter SKIP_BINS, default 2, meaning low bins (DC region) excluded from the search.
REQ-004 SHALL have parameter GAP_TIMEOUT, default 16, meaning the maximum consecutive idle cycles allowed inside a frame.
REQ-005 SHALL have port aclk, input, 1, clock.
REQ-006 SHALL have port aresetn, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port amp, input, AMP_W, unsigned magnitude-squared of the current bin.
REQ-008 SHALL have port amp_valid, input, 1, qualifies amp; one bin per high cycle, in natural order.
REQ-009 SHALL have port threshold, input, AMP_W, detection threshold, sampled when the result is latched.
REQ-010 SHALL have port peak_bin, output, log2(FFT_LEN), index of the maximum bin.
REQ-011 SHALL have port peak_amp, output, AMP_W, magnitude of the maximum bin.
REQ-012 SHALL have port peak_hit, output, 1, peak_amp >= threshold.
REQ-013 SHALL have port result_valid, output, 1, the result registers hold an unread frame result.
REQ-014 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-015 SHALL have port frame_cnt, output, 16, completed-frame counter.
REQ-016 SHALL have port overrun, output, 1, one-cycle pulse: an unread result was overwritten.
REQ-017 SHALL have port frame_err, output, 1, one-cycle pulse: a frame was aborted on gap timeout.

Function
REQ-018 SHALL implement FSM states IDLE and SCAN; IDLE->SCAN on amp_valid (that beat is bin 0); SCAN->IDLE on the bin FFT_LEN-1 beat or on gap abort.
REQ-019 SHALL count bins with a wrapping log2(FFT_LEN)-bit counter, advanced only on amp_valid beats.
REQ-020 SHALL compare only bins in [SKIP_BINS, FFT_LEN/2-1]; the running best is cleared to amp=0, bin=SKIP_BINS at the start of each frame.
REQ-021 SHALL replace the best only when amp > best (strict), so the lowest index wins ties.
REQ-022 SHALL, on the bin FFT_LEN-1 beat, latch peak_bin, peak_amp and peak_hit, increment frame_cnt modulo 2^16, and assert result_valid on the next cycle (1-cycle latency).
REQ-023 SHALL hold result_valid and the result registers until a cycle with result_valid && result_ready, then deassert result_valid.
REQ-024 SHALL, when a frame completes while result_valid=1 and result_ready=0, overwrite the results, keep result_valid=1 and pulse overrun; completion coinciding with acceptance SHALL NOT pulse overrun.
REQ-025 SHALL count consecutive amp_valid=0 cycles in SCAN; on reaching GAP_TIMEOUT it SHALL pulse frame_err, return to IDLE and discard the partial best, and SHALL NOT change the result registers or frame_cnt.
REQ-026 SHALL accept back-to-back frames with zero idle cycles: the beat after bin FFT_LEN-1 is bin 0 of the next frame.
REQ-027 SHALL never stall the input; no ready is returned upstream.

Reset
REQ-028 SHALL, while aresetn=0, force state=IDLE, all counters=0, peak_bin=0, peak_amp=0, peak_hit=0, result_valid=0, overrun=0, frame_err=0.
REQ-029 SHALL, on reset mid-frame, drop the partial frame without producing a result; the first amp_valid after release is bin 0.

Structure
REQ-030 SHALL take the FSM state encoding and default FFT_LEN/AMP_W constants from a shared package (fft_pkg) used by the FFT stage.
REQ-031 SHALL be a single module; the argmax compare/update MAY be a sub-module named peak_cmp.

Verification
REQ-032 SHALL cover: one frame with amp=bin index except bin 300=1e9, threshold=5e8 -> peak_bin=300, peak_amp=1e9, peak_hit=1, result_valid one cycle after bin 2047.
REQ-033 SHALL cover: bins 0,1 = 2^46, bins 100 and 200 both = 5000, rest 0 -> peak_bin=100 (DC skipped, tie to lowest).
REQ-034 SHALL cover: bin 1500 = max value, bins 2..1023 = 10 -> peak_bin=2 with peak_amp=10 (upper half ignored).
REQ-035 SHALL cover: two back-to-back frames with result_ready=0 -> overrun pulses once, second result held, frame_cnt=2.
REQ-036 SHALL cover: amp_valid dropped for 16 cycles after bin 500 -> frame_err pulse, no result_valid, frame_cnt unchanged; next full frame reports normally.
REQ-037 SHALL cover: aresetn asserted at bin 1000 -> all outputs 0; the following full frame is reported with frame_cnt=1.
